// File: rtl/fma_normalize.sv
// Post-addition normalization for the single-precision FMA: leading-zero count in stage 1,
// shift plus sticky reduction in stage 2, feeding a 27-bit significand to the rounding stage.
module fma_normalize #(
  parameter int SUM_W = 50,
  parameter int EXP_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [26:0]      out_sig,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_unf
);

  localparam int LZ_W = $clog2(SUM_W + 1);

  logic             r_s1Valid;
  logic             r_s1Sign;
  logic             r_s1Zero;
  logic [EXP_W-1:0] r_s1Exp;
  logic [SUM_W-1:0] r_s1Sum;
  logic [LZ_W-1:0]  r_s1Lz;

  logic             r_s2Valid;
  logic             r_outSign;
  logic [EXP_W-1:0] r_outExp;
  logic [26:0]      r_outSig;
  logic             r_outZero;
  logic             r_outOvf;
  logic             r_outUnf;

  logic             w_s1Advance;
  logic [LZ_W-1:0]  w_lz;
  logic             w_zero;
  logic [EXP_W:0]   w_expExt;
  logic [EXP_W:0]   w_lzExt;
  logic             w_expPos;
  logic             w_denorm;
  logic [LZ_W-1:0]  w_shift;
  logic [SUM_W-1:0] w_norm;
  logic [26:0]      w_sigRaw;
  logic [EXP_W:0]   w_e;
  logic             w_ovfRaw;
  logic [26:0]      w_nxtSig;
  logic [EXP_W-1:0] w_nxtExp;
  logic             w_nxtZero;
  logic             w_nxtOvf;
  logic             w_nxtUnf;

  assign w_s1Advance = !r_s2Valid || out_ready;
  assign in_ready    = !r_s1Valid || w_s1Advance;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    w_lz = LZ_W'(SUM_W);
    for (int i = 0; i < SUM_W; i++) begin
      if (in_sum[i]) w_lz = LZ_W'(SUM_W - 1 - i);
    end
  end

  assign w_zero = (in_sum == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Sign  <= 1'b0;
      r_s1Zero  <= 1'b0;
      r_s1Exp   <= '0;
      r_s1Sum   <= '0;
      r_s1Lz    <= '0;
    end else if (in_ready) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_s1Sign <= in_sign;
        r_s1Zero <= w_zero;
        r_s1Exp  <= in_exp;
        r_s1Sum  <= in_sum;
        r_s1Lz   <= w_lz;
      end
    end
  end

  // Both operands are non-negative whenever w_denorm matters, so an unsigned compare is safe.
  assign w_expExt = {r_s1Exp[EXP_W-1], r_s1Exp};
  assign w_lzExt  = (EXP_W+1)'(r_s1Lz);
  assign w_expPos = !r_s1Exp[EXP_W-1] && (r_s1Exp != '0);
  assign w_denorm = !r_s1Zero && w_expPos && (w_lzExt > w_expExt);

  always_comb begin
    w_shift = '0;
    if (!r_s1Zero && w_expPos) w_shift = w_denorm ? r_s1Exp[LZ_W-1:0] : r_s1Lz;
  end

  assign w_norm   = r_s1Sum << w_shift;
  assign w_sigRaw = {w_norm[SUM_W-1 -: 26], |w_norm[SUM_W-27:0]};
  assign w_e      = w_expExt + (EXP_W+1)'(1) - (EXP_W+1)'(w_shift);
  assign w_ovfRaw = $signed(w_e) >= $signed((EXP_W+1)'(255));

  always_comb begin
    w_nxtSig  = '0;
    w_nxtExp  = '0;
    w_nxtZero = 1'b0;
    w_nxtOvf  = 1'b0;
    w_nxtUnf  = 1'b0;
    if (r_s1Zero) begin
      w_nxtZero = 1'b1;
    end else if (!w_expPos) begin
      w_nxtUnf = 1'b1;
    end else if (w_denorm) begin
      w_nxtSig = w_sigRaw;
      w_nxtUnf = 1'b1;
    end else begin
      w_nxtSig = w_sigRaw;
      w_nxtExp = w_e[EXP_W-1:0];
      w_nxtOvf = w_ovfRaw;
    end
  end

  // Output word only changes on a stage-1 advance, so it holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2Valid <= 1'b0;
      r_outSign <= 1'b0;
      r_outExp  <= '0;
      r_outSig  <= '0;
      r_outZero <= 1'b0;
      r_outOvf  <= 1'b0;
      r_outUnf  <= 1'b0;
    end else if (w_s1Advance) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_outSign <= r_s1Sign;
        r_outExp  <= w_nxtExp;
        r_outSig  <= w_nxtSig;
        r_outZero <= w_nxtZero;
        r_outOvf  <= w_nxtOvf;
        r_outUnf  <= w_nxtUnf;
      end
    end
  end

  assign out_valid = r_s2Valid;
  assign out_sign  = r_outSign;
  assign out_exp   = r_outExp;
  assign out_sig   = r_outSig;
  assign out_zero  = r_outZero;
  assign out_ovf   = r_outOvf;
  assign out_unf   = r_outUnf;

endmodule

// File: tb/tb_fma_normalize.sv
// Directed bench for fma_normalize: hand-computed vectors, backpressure ordering and mid-flight reset.
module tb_fma_normalize;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [49:0] in_sum;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [9:0]  out_exp;
  logic [26:0] out_sig;
  logic        out_zero;
  logic        out_ovf;
  logic        out_unf;

  int testCount = 0;
  int failCount = 0;

  fma_normalize #(.SUM_W(50), .EXP_W(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sign  (in_sign),
    .in_exp   (in_exp),
    .in_sum   (in_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sign (out_sign),
    .out_exp  (out_exp),
    .out_sig  (out_sig),
    .out_zero (out_zero),
    .out_ovf  (out_ovf),
    .out_unf  (out_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic driveItem(input logic sign, input logic [9:0] exp, input logic [49:0] sum);
    in_valid = 1'b1;
    in_sign  = sign;
    in_exp   = exp;
    in_sum   = sum;
  endtask

  // Full-word check of the current output against expected fields.
  task automatic checkWord(input string tag, input logic sign, input logic [26:0] eSig, input logic [9:0] eExp,
                           input logic eZero, input logic eOvf, input logic eUnf);
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, ".sign"},  32'(out_sign),  32'(sign));
    checkOutput({tag, ".sig"},   32'(out_sig),   32'(eSig));
    checkOutput({tag, ".exp"},   32'(out_exp),   32'(eExp));
    checkOutput({tag, ".zero"},  32'(out_zero),  32'(eZero));
    checkOutput({tag, ".ovf"},   32'(out_ovf),   32'(eOvf));
    checkOutput({tag, ".unf"},   32'(out_unf),   32'(eUnf));
  endtask

  // One item through an idle pipeline with out_ready high; also checks the 2-cycle latency.
  task automatic applyStimulus(input string tag, input logic sign, input logic [9:0] exp, input logic [49:0] sum,
                               input logic [26:0] eSig, input logic [9:0] eExp,
                               input logic eZero, input logic eOvf, input logic eUnf);
    @(negedge clk);
    checkOutput({tag, ".inReady"}, 32'(in_ready), 32'd1);
    driveItem(sign, exp, sum);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput({tag, ".early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    checkWord(tag, sign, eSig, eExp, eZero, eOvf, eUnf);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_sum    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst.outValid", 32'(out_valid), 32'd0);
    checkOutput("rst.inReady",  32'(in_ready),  32'd1);
    checkOutput("rst.sig",      32'(out_sig),   32'd0);
    checkOutput("rst.exp",      32'(out_exp),   32'd0);
    checkOutput("rst.flags",    32'({out_sign, out_zero, out_ovf, out_unf}), 32'd0);

    applyStimulus("carry",     1'b0, 10'd127, 50'h1 << 49,                 27'h4000000, 10'd128, 0, 0, 0);
    applyStimulus("sticky",    1'b0, 10'd127, (50'h1 << 48) | 50'h1,       27'h4000001, 10'd127, 0, 0, 0);
    applyStimulus("guardRnd",  1'b0, 10'd100, (50'h1 << 48) | (50'h3 << 23), 27'h4000006, 10'd100, 0, 0, 0);
    applyStimulus("lowSticky", 1'b0, 10'd100, (50'h1 << 48) | (50'h3 << 21), 27'h4000001, 10'd100, 0, 0, 0);
    applyStimulus("signPass",  1'b1, 10'd127, (50'h1 << 48) | 50'h1,       27'h4000001, 10'd127, 0, 0, 0);
    applyStimulus("zero",      1'b0, 10'd50,  50'h0,                       27'h0,       10'd0,   1, 0, 0);
    applyStimulus("denorm",    1'b0, 10'd3,   50'h1 << 40,                 27'h0100000, 10'd0,   0, 0, 1);
    applyStimulus("denormStk", 1'b0, 10'd5,   (50'h1 << 30) | 50'h1,       27'h0001001, 10'd0,   0, 0, 1);
    applyStimulus("flushZero", 1'b0, 10'd0,   50'h1 << 48,                 27'h0,       10'd0,   0, 0, 1);
    applyStimulus("flushNeg",  1'b1, 10'h3F0, 50'h1 << 49,                 27'h0,       10'd0,   0, 0, 1);
    applyStimulus("lzEqExp",   1'b0, 10'd4,   50'h1 << 45,                 27'h4000000, 10'd1,   0, 0, 0);
    applyStimulus("bigShift",  1'b0, 10'd100, 50'h1,                       27'h4000000, 10'd52,  0, 0, 0);
    applyStimulus("ovfEdge",   1'b0, 10'd254, 50'h1 << 49,                 27'h4000000, 10'd255, 0, 1, 0);
    applyStimulus("belowOvf",  1'b0, 10'd254, 50'h1 << 48,                 27'h4000000, 10'd254, 0, 0, 0);

    // Backpressure: A and B fill both stages, C must wait until the output drains.
    @(negedge clk);
    out_ready = 1'b0;
    driveItem(1'b0, 10'd127, 50'h1 << 49);
    @(negedge clk);
    driveItem(1'b0, 10'd127, (50'h1 << 48) | 50'h1);
    @(negedge clk);
    driveItem(1'b0, 10'd100, (50'h1 << 48) | (50'h3 << 23));
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp.inReadyLow", 32'(in_ready), 32'd0);
      checkWord("bp.holdA", 1'b0, 27'h4000000, 10'd128, 0, 0, 0);
      @(negedge clk);
    end
    checkWord("bp.holdA", 1'b0, 27'h4000000, 10'd128, 0, 0, 0);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkWord("bp.B", 1'b0, 27'h4000001, 10'd127, 0, 0, 0);
    @(negedge clk);
    checkWord("bp.C", 1'b0, 27'h4000006, 10'd100, 0, 0, 0);
    @(negedge clk);
    checkOutput("bp.drained", 32'(out_valid), 32'd0);

    // Mid-flight reset with two items inside.
    out_ready = 1'b0;
    driveItem(1'b0, 10'd127, 50'h1 << 49);
    @(negedge clk);
    driveItem(1'b0, 10'd100, 50'h1);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    checkOutput("midRst.outValid", 32'(out_valid), 32'd0);
    checkOutput("midRst.inReady",  32'(in_ready),  32'd1);
    checkOutput("midRst.sig",      32'(out_sig),   32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("midRst.noStale", 32'(out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
